// File: rtl/sobel_config_pkg.sv
// rtl/sobel_config_pkg.sv - shared Sobel configuration: host sequencer states and defaults
// Purpose: types and constants shared by the Sobel host-side sequencer and its FIFO.
// Ports: none (package).
package sobel_config_pkg;

  typedef enum logic [2:0] {
    HC_IDLE,
    HC_LOAD,
    HC_START,
    HC_WAIT,
    HC_DRAIN,
    HC_DONE,
    HC_ERR
  } host_state_e;

  localparam int HOST_TIMEOUT_CYCLES = 2**20;

endpackage

// File: rtl/sobel_out_fifo.sv
// rtl/sobel_out_fifo.sv - 2-entry registered output FIFO for the host drain path
// Purpose: buffers words read back from the output memory; the head is a flop so the
//          downstream stream never sees a combinational path into memory control.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i/push_data_i  write a word (legal together with pop, also when full)
//   pop_i               remove the head (ignored when empty)
//   valid_o, head_o     non-empty flag and registered head word
//   count_o             occupancy 0..2
module sobel_out_fifo #(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  // e0 is always the head; e1 only holds data when two words are stored.
  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_pop;

  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    cnt_d  = cnt_q;
    do_pop = pop_i && (cnt_q != 2'd0);
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          e0_d  = push_data_i;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && do_pop) begin
          e0_d = push_data_i;
        end else if (push_i) begin
          e1_d  = push_data_i;
          cnt_d = 2'd2;
        end else if (do_pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        // Full: a push is only accepted when the head leaves in the same cycle.
        if (do_pop) begin
          e0_d = e1_q;
          if (push_i) begin
            e1_d = push_data_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/sobel_host_ctrl.sv
// rtl/sobel_host_ctrl.sv - streaming host sequencer around sobel_top
// Purpose: loads an input pixel stream into sobel_top input memory, starts the core,
//          waits for finish (with timeout), then drains the output memory as a stream.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   go_i, busy_o, done_o, err_o       frame control / status
//   in_valid_i, in_data_i, in_ready_o input pixel stream (raster order)
//   out_valid_o, out_data_o,
//   out_last_o, out_ready_i           output pixel stream (raster order)
//   start_o, finish_i                 sobel_top start / finish
//   wr_en_imem_o, addr_imem_o,
//   data_imem_o                       sobel_top input memory write port
//   rd_en_omem_o, addr_omem_o,
//   data_omem_i                       sobel_top output memory read port (1-cycle latency)
module sobel_host_ctrl
  import sobel_config_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int IMAGE_ROWS     = 64,
  parameter int IMAGE_COLS     = 64,
  parameter int TIMEOUT_CYCLES = HOST_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  start_o,
  input  logic                  finish_i,
  output logic                  wr_en_imem_o,
  output logic [ADDR_WIDTH-1:0] addr_imem_o,
  output logic [DATA_WIDTH-1:0] data_imem_o,
  output logic                  rd_en_omem_o,
  output logic [ADDR_WIDTH-1:0] addr_omem_o,
  input  logic [DATA_WIDTH-1:0] data_omem_i
);

  localparam int PIXELS = IMAGE_ROWS * IMAGE_COLS;
  // One extra bit so a full 2**ADDR_WIDTH frame can be counted without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0] PIX_END  = CNT_W'(PIXELS);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  host_state_e      state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic             inflight_q, inflight_d;
  logic             last_inflight_q, last_inflight_d;
  logic             fin_prev_q, fin_prev_d;

  logic                  fifo_valid;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_pop;

  sobel_out_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_out_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (inflight_q),
    .push_data_i({last_inflight_q, data_omem_i}),
    .pop_i      (fifo_pop),
    .valid_o    (fifo_valid),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  // Pop depends only on registered FIFO state and out_ready_i; the read issue below
  // uses the registered count, so out_ready_i never reaches the memory signals.
  assign fifo_pop = (state_q == HC_DRAIN) && fifo_valid && out_ready_i;

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    rcnt_d          = rcnt_q;
    tcnt_d          = tcnt_q;
    inflight_d      = 1'b0;
    last_inflight_d = 1'b0;
    fin_prev_d      = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    in_ready_o      = 1'b0;
    out_valid_o     = 1'b0;
    out_data_o      = '0;
    out_last_o      = 1'b0;
    start_o         = 1'b0;
    wr_en_imem_o    = 1'b0;
    addr_imem_o     = '0;
    data_imem_o     = '0;
    rd_en_omem_o    = 1'b0;
    addr_omem_o     = '0;

    case (state_q)
      HC_IDLE: begin
        if (go_i) begin
          state_d = HC_LOAD;
          wcnt_d  = '0;
          rcnt_d  = '0;
        end
      end
      HC_LOAD: begin
        busy_o     = 1'b1;
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wr_en_imem_o = 1'b1;
          addr_imem_o  = wcnt_q[ADDR_WIDTH-1:0];
          data_imem_o  = in_data_i;
          wcnt_d       = wcnt_q + 1'b1;
          if (wcnt_q == PIX_LAST) begin
            state_d = HC_START;
          end
        end
      end
      HC_START: begin
        busy_o  = 1'b1;
        start_o = 1'b1;
        // Counts cycles since the start pulse, so ERR lands TIMEOUT_CYCLES after it.
        tcnt_d  = TMO_W'(1);
        state_d = HC_WAIT;
      end
      HC_WAIT: begin
        busy_o = 1'b1;
        // fin_prev_q is 0 on WAIT entry, so a level already high counts as an edge.
        fin_prev_d = finish_i;
        if (finish_i && !fin_prev_q) begin
          state_d = HC_DRAIN;
        end else if (tcnt_q >= TMO_LAST) begin
          state_d = HC_ERR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      HC_DRAIN: begin
        busy_o      = 1'b1;
        out_valid_o = fifo_valid;
        out_data_o  = fifo_head[DATA_WIDTH-1:0];
        out_last_o  = fifo_valid && fifo_head[DATA_WIDTH];
        // Outstanding reads plus buffered words never exceed the two FIFO slots.
        if ((rcnt_q < PIX_END) && ((fifo_count + {1'b0, inflight_q}) < 2'd2)) begin
          rd_en_omem_o    = 1'b1;
          addr_omem_o     = rcnt_q[ADDR_WIDTH-1:0];
          rcnt_d          = rcnt_q + 1'b1;
          inflight_d      = 1'b1;
          last_inflight_d = (rcnt_q == PIX_LAST);
        end
        if (fifo_pop && fifo_head[DATA_WIDTH]) begin
          state_d = HC_DONE;
        end
      end
      HC_DONE: begin
        done_o  = 1'b1;
        state_d = HC_IDLE;
      end
      HC_ERR: begin
        err_o = 1'b1;
        if (go_i) begin
          state_d = HC_IDLE;
        end
      end
      default: begin
        state_d = HC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= HC_IDLE;
      wcnt_q          <= '0;
      rcnt_q          <= '0;
      tcnt_q          <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      fin_prev_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      rcnt_q          <= rcnt_d;
      tcnt_q          <= tcnt_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
      fin_prev_q      <= fin_prev_d;
    end
  end

endmodule
